// File: rtl/vend_pkg.sv
// Shared types and default widths for the vending transaction controller.
package vend_pkg;

    localparam int CURRENCY_WIDTH_DEF  = 7;
    localparam int ITEM_ADDR_WIDTH_DEF = 10;
    localparam int TIMEOUT_CYCLES_DEF  = 1000;
    localparam int PRICE_WIDTH         = 16;
    localparam int COUNT_WIDTH         = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_LOOKUP,
        ST_DECIDE,
        ST_DISPENSE,
        ST_REFUND
    } vend_state_e;

endpackage

// File: rtl/vend_credit_acc.sv
// Credit accumulator: adds coins only while the sum fits, flags rejected coins.
module vend_credit_acc
    import vend_pkg::*;
#(
    parameter int CURRENCY_WIDTH = CURRENCY_WIDTH_DEF
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      coin_valid,
    input  logic [CURRENCY_WIDTH-1:0] coin_value,
    input  logic                      coin_allow,
    input  logic                      clear,
    output logic [CURRENCY_WIDTH-1:0] total,
    output logic [CURRENCY_WIDTH-1:0] total_next,
    output logic                      coin_accept,
    output logic                      coin_reject
);

    logic [CURRENCY_WIDTH:0] sum;

    // The carry bit of the widened sum is the "exceeds max credit" flag.
    always_comb begin
        sum         = {1'b0, total} + {1'b0, coin_value};
        coin_accept = coin_valid && coin_allow && !sum[CURRENCY_WIDTH];
        total_next  = total;
        if (clear) begin
            total_next = '0;
        end else if (coin_accept) begin
            total_next = sum[CURRENCY_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            total       <= '0;
            coin_reject <= 1'b0;
        end else begin
            total       <= total_next;
            coin_reject <= coin_valid && !coin_accept;
        end
    end

endmodule

// File: rtl/vend_txn_ctrl.sv
// Vending transaction sequencer: coin collection, item lookup, dispense/refund
// decision and stock write-back.
module vend_txn_ctrl
    import vend_pkg::*;
#(
    parameter int CURRENCY_WIDTH  = CURRENCY_WIDTH_DEF,
    parameter int ITEM_ADDR_WIDTH = ITEM_ADDR_WIDTH_DEF,
    parameter int TIMEOUT_CYCLES  = TIMEOUT_CYCLES_DEF
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       coin_valid,
    input  logic [CURRENCY_WIDTH-1:0]  coin_value,
    output logic                       coin_reject,
    input  logic                       select_valid,
    input  logic [ITEM_ADDR_WIDTH-1:0] select_item,
    input  logic                       cancel,
    output logic                       mem_rd_en,
    output logic [ITEM_ADDR_WIDTH-1:0] mem_addr,
    input  logic [PRICE_WIDTH-1:0]     mem_rd_price,
    input  logic [COUNT_WIDTH-1:0]     mem_rd_count,
    output logic                       mem_wr_en,
    output logic [COUNT_WIDTH-1:0]     mem_wr_count,
    output logic [CURRENCY_WIDTH-1:0]  total_currency,
    output logic                       dispense_valid,
    output logic                       trigger_dispense,
    output logic [ITEM_ADDR_WIDTH-1:0] item_dispensed,
    output logic [CURRENCY_WIDTH-1:0]  currency_change,
    input  logic                       dispense_ack,
    output logic                       sold_out,
    output logic                       insufficient_funds,
    output logic                       busy
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    vend_state_e                state;
    logic [TW-1:0]              tmo_cnt;
    logic [ITEM_ADDR_WIDTH-1:0] item_q;

    logic                      coin_allow;
    logic                      credit_clear;
    logic                      coin_accept;
    logic [CURRENCY_WIDTH-1:0] total;
    logic [CURRENCY_WIDTH-1:0] total_next;
    logic [PRICE_WIDTH-1:0]    total_ext;
    logic                      can_buy;
    logic                      timed_out;

    always_comb begin
        coin_allow   = (state == ST_IDLE) || (state == ST_COLLECT);
        credit_clear = dispense_ack && ((state == ST_DISPENSE) || (state == ST_REFUND));
        total_ext    = PRICE_WIDTH'(total);
        can_buy      = (mem_rd_count != '0) && (total_ext >= mem_rd_price);
        timed_out    = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
    end

    vend_credit_acc #(
        .CURRENCY_WIDTH (CURRENCY_WIDTH)
    ) u_credit (
        .clk         (clk),
        .rstn        (rstn),
        .coin_valid  (coin_valid),
        .coin_value  (coin_value),
        .coin_allow  (coin_allow),
        .clear       (credit_clear),
        .total       (total),
        .total_next  (total_next),
        .coin_accept (coin_accept),
        .coin_reject (coin_reject)
    );

    assign total_currency = total;

    // Memory data answers the read strobe issued in LOOKUP, so it is only
    // valid during DECIDE; the decision uses it directly there.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state              <= ST_IDLE;
            tmo_cnt            <= '0;
            item_q             <= '0;
            mem_rd_en          <= 1'b0;
            mem_addr           <= '0;
            mem_wr_en          <= 1'b0;
            mem_wr_count       <= '0;
            dispense_valid     <= 1'b0;
            trigger_dispense   <= 1'b0;
            item_dispensed     <= '0;
            currency_change    <= '0;
            sold_out           <= 1'b0;
            insufficient_funds <= 1'b0;
            busy               <= 1'b0;
        end else begin
            mem_rd_en          <= 1'b0;
            mem_wr_en          <= 1'b0;
            sold_out           <= 1'b0;
            insufficient_funds <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (coin_valid) begin
                        state   <= ST_COLLECT;
                        tmo_cnt <= '0;
                        busy    <= 1'b1;
                    end
                end

                ST_COLLECT: begin
                    if (cancel) begin
                        state            <= ST_REFUND;
                        dispense_valid   <= 1'b1;
                        trigger_dispense <= 1'b0;
                        item_dispensed   <= '0;
                        currency_change  <= total_next;
                    end else if (select_valid) begin
                        state     <= ST_LOOKUP;
                        item_q    <= select_item;
                        mem_addr  <= select_item;
                        mem_rd_en <= 1'b1;
                        tmo_cnt   <= '0;
                    end else if (coin_accept) begin
                        tmo_cnt <= '0;
                    end else if (timed_out) begin
                        state            <= ST_REFUND;
                        dispense_valid   <= 1'b1;
                        trigger_dispense <= 1'b0;
                        item_dispensed   <= '0;
                        currency_change  <= total_next;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end

                ST_LOOKUP: begin
                    state <= ST_DECIDE;
                end

                ST_DECIDE: begin
                    if (can_buy) begin
                        state            <= ST_DISPENSE;
                        mem_wr_en        <= 1'b1;
                        mem_wr_count     <= mem_rd_count - 1'b1;
                        mem_addr         <= item_q;
                        dispense_valid   <= 1'b1;
                        trigger_dispense <= 1'b1;
                        item_dispensed   <= item_q;
                        currency_change  <= total - mem_rd_price[CURRENCY_WIDTH-1:0];
                    end else if (mem_rd_count == '0) begin
                        state            <= ST_REFUND;
                        sold_out         <= 1'b1;
                        dispense_valid   <= 1'b1;
                        trigger_dispense <= 1'b0;
                        item_dispensed   <= item_q;
                        currency_change  <= total;
                    end else begin
                        state              <= ST_COLLECT;
                        insufficient_funds <= 1'b1;
                        tmo_cnt            <= '0;
                    end
                end

                ST_DISPENSE, ST_REFUND: begin
                    if (dispense_ack) begin
                        state            <= ST_IDLE;
                        busy             <= 1'b0;
                        dispense_valid   <= 1'b0;
                        trigger_dispense <= 1'b0;
                        item_dispensed   <= '0;
                        currency_change  <= '0;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vend_txn_ctrl.sv
// Directed table-driven bench for vend_txn_ctrl with a registered-read item memory model.
module tb_vend_txn_ctrl;

    localparam int CW = 7;
    localparam int AW = 10;
    localparam int TMO = 20;

    logic          clk = 1'b0;
    logic          rstn;
    logic          coin_valid;
    logic [CW-1:0] coin_value;
    logic          coin_reject;
    logic          select_valid;
    logic [AW-1:0] select_item;
    logic          cancel;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_rd_price;
    logic [7:0]    mem_rd_count;
    logic          mem_wr_en;
    logic [7:0]    mem_wr_count;
    logic [CW-1:0] total_currency;
    logic          dispense_valid;
    logic          trigger_dispense;
    logic [AW-1:0] item_dispensed;
    logic [CW-1:0] currency_change;
    logic          dispense_ack;
    logic          sold_out;
    logic          insufficient_funds;
    logic          busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vend_txn_ctrl #(
        .CURRENCY_WIDTH  (CW),
        .ITEM_ADDR_WIDTH (AW),
        .TIMEOUT_CYCLES  (TMO)
    ) dut (
        .clk                (clk),
        .rstn               (rstn),
        .coin_valid         (coin_valid),
        .coin_value         (coin_value),
        .coin_reject        (coin_reject),
        .select_valid       (select_valid),
        .select_item        (select_item),
        .cancel             (cancel),
        .mem_rd_en          (mem_rd_en),
        .mem_addr           (mem_addr),
        .mem_rd_price       (mem_rd_price),
        .mem_rd_count       (mem_rd_count),
        .mem_wr_en          (mem_wr_en),
        .mem_wr_count       (mem_wr_count),
        .total_currency     (total_currency),
        .dispense_valid     (dispense_valid),
        .trigger_dispense   (trigger_dispense),
        .item_dispensed     (item_dispensed),
        .currency_change    (currency_change),
        .dispense_ack       (dispense_ack),
        .sold_out           (sold_out),
        .insufficient_funds (insufficient_funds),
        .busy               (busy)
    );

    // Item memory: item 2 (40, 5), item 5 (50, 3), item 7 (30, 0)
    bit [7:0] cnt_mem [0:1023];
    bit       written [0:1023];
    int       wr_cnt = 0;

    function automatic logic [15:0] price_of(input logic [AW-1:0] a);
        case (a)
            10'd2:   return 16'd40;
            10'd5:   return 16'd50;
            10'd7:   return 16'd30;
            default: return 16'd0;
        endcase
    endfunction

    function automatic logic [7:0] init_count(input logic [AW-1:0] a);
        case (a)
            10'd2:   return 8'd5;
            10'd5:   return 8'd3;
            default: return 8'd0;
        endcase
    endfunction

    function automatic logic [7:0] cur_count(input logic [AW-1:0] a);
        return written[a] ? cnt_mem[a] : init_count(a);
    endfunction

    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_rd_price <= price_of(mem_addr);
            mem_rd_count <= cur_count(mem_addr);
        end
        if (mem_wr_en) begin
            cnt_mem[mem_addr] <= mem_wr_count;
            written[mem_addr] <= 1'b1;
            wr_cnt            <= wr_cnt + 1;
        end
    end

    typedef struct packed {
        logic          busy;
        logic          dv;
        logic          trig;
        logic          rej;
        logic          rd;
        logic          wr;
        logic          so;
        logic          ins;
        logic [CW-1:0] total;
        logic [CW-1:0] chg;
        logic [AW-1:0] item;
        logic [AW-1:0] addr;
    } out_t;

    typedef struct packed {
        logic          cv;
        logic [CW-1:0] cval;
        logic          sv;
        logic [AW-1:0] sitem;
        logic          can;
        logic          ack;
        out_t          exp;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic cv, input int cval, input logic sv, input int sitem,
        input logic can, input logic ack,
        input logic b, input logic dv, input logic tr, input logic rj,
        input logic rd, input logic wr, input logic so, input logic ins,
        input int tot, input int chg, input int item, input int addr);
        vec_t v;
        v.cv = cv; v.cval = CW'(cval); v.sv = sv; v.sitem = AW'(sitem);
        v.can = can; v.ack = ack;
        v.exp.busy = b; v.exp.dv = dv; v.exp.trig = tr; v.exp.rej = rj;
        v.exp.rd = rd; v.exp.wr = wr; v.exp.so = so; v.exp.ins = ins;
        v.exp.total = CW'(tot); v.exp.chg = CW'(chg);
        v.exp.item = AW'(item); v.exp.addr = AW'(addr);
        return v;
    endfunction

    function automatic out_t sample();
        out_t o;
        o.busy = busy; o.dv = dispense_valid; o.trig = trigger_dispense;
        o.rej = coin_reject; o.rd = mem_rd_en; o.wr = mem_wr_en;
        o.so = sold_out; o.ins = insufficient_funds;
        o.total = total_currency; o.chg = currency_change;
        o.item = item_dispensed; o.addr = mem_addr;
        return o;
    endfunction

    task automatic check_out(input string name, input out_t want);
        out_t got;
        got = sample();
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %p want %p", name, got, want);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic drive(input logic cv, input int cval, input logic sv,
                         input int sitem, input logic can, input logic ack);
        coin_valid = cv; coin_value = CW'(cval); select_valid = sv;
        select_item = AW'(sitem); cancel = can; dispense_ack = ack;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        out_t zero_o;
        out_t w;
        int   wr_before;
        zero_o = '0;

        rstn = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        step();
        step();
        check_out("reset_state", zero_o);
        rstn = 1'b1;

        //        cv cval sv it cn ak | b dv tr rj rd wr so in tot chg itm adr
        // coins 25+25+10, buy item 5; coin during LOOKUP rejected
        tbl.push_back(mk(1, 25, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0,  25,  0, 0, 0));
        tbl.push_back(mk(1, 25, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0,  50,  0, 0, 0));
        tbl.push_back(mk(1, 10, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0,  60,  0, 0, 0));
        tbl.push_back(mk(0,  0, 1, 5, 0, 0,  1, 0, 0, 0, 1, 0, 0, 0,  60,  0, 0, 5));
        tbl.push_back(mk(1,  5, 0, 0, 0, 0,  1, 0, 0, 1, 0, 0, 0, 0,  60,  0, 0, 5));
        tbl.push_back(mk(0,  0, 0, 0, 0, 0,  1, 1, 1, 0, 0, 1, 0, 0,  60, 10, 5, 5));
        tbl.push_back(mk(0,  0, 0, 0, 0, 0,  1, 1, 1, 0, 0, 0, 0, 0,  60, 10, 5, 5));
        tbl.push_back(mk(0,  0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0,   0,  0, 0, 5));
        // select/cancel/ack ignored in IDLE
        tbl.push_back(mk(0,  0, 1, 9, 1, 1,  0, 0, 0, 0, 0, 0, 0, 0,   0,  0, 0, 5));
        // item 7 sold out
        tbl.push_back(mk(1, 50, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0,  50,  0, 0, 5));
        tbl.push_back(mk(0,  0, 1, 7, 0, 0,  1, 0, 0, 0, 1, 0, 0, 0,  50,  0, 0, 7));
        tbl.push_back(mk(0,  0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0,  50,  0, 0, 7));
        tbl.push_back(mk(0,  0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 1, 0,  50, 50, 7, 7));
        tbl.push_back(mk(0,  0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0, 0,  50, 50, 7, 7));
        tbl.push_back(mk(0,  0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0,   0,  0, 0, 7));
        // item 2 underfunded, then coin+select together; coin in DISPENSE rejected
        tbl.push_back(mk(1, 20, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0,  20,  0, 0, 7));
        tbl.push_back(mk(0,  0, 1, 2, 0, 0,  1, 0, 0, 0, 1, 0, 0, 0,  20,  0, 0, 2));
        tbl.push_back(mk(0,  0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0,  20,  0, 0, 2));
        tbl.push_back(mk(0,  0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 1,  20,  0, 0, 2));
        tbl.push_back(mk(1, 20, 1, 2, 0, 0,  1, 0, 0, 0, 1, 0, 0, 0,  40,  0, 0, 2));
        tbl.push_back(mk(0,  0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0,  40,  0, 0, 2));
        tbl.push_back(mk(0,  0, 0, 0, 0, 0,  1, 1, 1, 0, 0, 1, 0, 0,  40,  0, 2, 2));
        tbl.push_back(mk(1,  5, 0, 0, 0, 0,  1, 1, 1, 1, 0, 0, 0, 0,  40,  0, 2, 2));
        tbl.push_back(mk(0,  0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0,   0,  0, 0, 2));
        // overflow: 120+10 rejected, 120+7=127 accepted, 127+1 rejected, cancel
        tbl.push_back(mk(1, 60, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0,  60,  0, 0, 2));
        tbl.push_back(mk(1, 60, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 120,  0, 0, 2));
        tbl.push_back(mk(1, 10, 0, 0, 0, 0,  1, 0, 0, 1, 0, 0, 0, 0, 120,  0, 0, 2));
        tbl.push_back(mk(1,  7, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 127,  0, 0, 2));
        tbl.push_back(mk(1,  1, 0, 0, 0, 0,  1, 0, 0, 1, 0, 0, 0, 0, 127,  0, 0, 2));
        tbl.push_back(mk(0,  0, 0, 0, 1, 0,  1, 1, 0, 0, 0, 0, 0, 0, 127,127, 0, 2));
        tbl.push_back(mk(0,  0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0,   0,  0, 0, 2));
        // cancel beats select: no read, refund of credit
        tbl.push_back(mk(1, 15, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0,  15,  0, 0, 2));
        tbl.push_back(mk(0,  0, 1, 5, 1, 0,  1, 1, 0, 0, 0, 0, 0, 0,  15, 15, 0, 2));
        tbl.push_back(mk(0,  0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0,   0,  0, 0, 2));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].cv, int'(tbl[i].cval), tbl[i].sv, int'(tbl[i].sitem),
                  tbl[i].can, tbl[i].ack);
            step();
            check_out($sformatf("vec%0d", i), tbl[i].exp);
        end
        drive(0, 0, 0, 0, 0, 0);

        check_int("stock_item5", int'(cur_count(10'd5)), 2);
        check_int("stock_item2", int'(cur_count(10'd2)), 4);
        check_int("stock_item7_untouched", int'(written[7]), 0);
        check_int("writes_after_table", wr_cnt, 2);

        // Timeout: credit 30 and no activity for TMO cycles in COLLECT
        drive(1, 30, 0, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < TMO - 1; i++) step();
        w = '0; w.busy = 1'b1; w.total = 7'd30; w.addr = 10'd2;
        check_out("timeout_not_yet", w);
        step();
        w.dv = 1'b1; w.chg = 7'd30;
        check_out("timeout_refund", w);
        drive(0, 0, 0, 0, 0, 1);
        step();
        drive(0, 0, 0, 0, 0, 0);
        w = '0; w.addr = 10'd2;
        check_out("timeout_ack_idle", w);

        // Reset asserted while holding a dispense of item 5
        drive(1, 50, 0, 0, 0, 0);
        step();
        drive(0, 0, 1, 5, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0);
        step();
        step();
        w = '0; w.busy = 1'b1; w.dv = 1'b1; w.trig = 1'b1; w.wr = 1'b1;
        w.total = 7'd50; w.chg = 7'd0; w.item = 10'd5; w.addr = 10'd5;
        check_out("dispense_before_reset", w);
        step();
        wr_before = wr_cnt;
        #2;
        rstn = 1'b0;
        #1;
        check_out("async_reset_outputs", zero_o);
        step();
        rstn = 1'b1;
        step();
        step();
        check_out("idle_after_reset", zero_o);
        check_int("no_write_after_reset", wr_cnt, wr_before);
        check_int("stock_item5_final", int'(cur_count(10'd5)), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
